// File: rtl/shift_chain_arbiter.sv
// Round-robin arbiter sharing one 74LS165 parallel-in/serial-out capture chain among NREQ requesters.
// The granted requester gets one load/shift sequence; the assembled word is returned tagged with its index.
module shift_chain_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned LANES = 2,
  parameter int unsigned BITS  = 8,
  localparam int unsigned SW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned DW   = LANES * BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic             shld,
  output logic             serclk,
  input  logic [LANES-1:0] sdin,
  output logic [DW-1:0]    data,
  output logic [SW-1:0]    data_src,
  output logic             data_valid,
  output logic             busy,
  output logic [4:0]       count
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t          state_q, state_n;
  logic            load_q, load_n;
  logic [4:0]      bit_q, bit_n;
  logic            phase_q, phase_n;
  logic [SW-1:0]   ptr_q, ptr_n;
  logic [SW-1:0]   src_q, src_n;
  logic [NREQ-1:0] gnt_n;
  logic            busy_n;
  logic            shld_n, serclk_n, shift_q, shift_n;
  logic [4:0]      count_n;

  logic [BITS-1:0] lane_sr [LANES];
  logic [DW-1:0]   data_n;
  logic            capture, last_sample;

  // Round-robin search: rotate the request vector so bit 0 is the pointer position.
  logic [2*NREQ-1:0] req_rot;
  logic              found;
  logic [31:0]       pick_sum;
  logic [SW-1:0]     pick;

  always_comb begin
    req_rot  = {req, req} >> ptr_q;
    found    = 1'b0;
    pick_sum = 32'(ptr_q);
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req_rot[i]) begin
        found    = 1'b1;
        pick_sum = 32'(ptr_q) + i;
      end
    end
    pick = (pick_sum >= NREQ) ? SW'(pick_sum - NREQ) : SW'(pick_sum);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      bit_q   <= 5'd0;
      phase_q <= 1'b0;
      ptr_q   <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_n;
      load_q  <= load_n;
      bit_q   <= bit_n;
      phase_q <= phase_n;
      ptr_q   <= ptr_n;
      src_q   <= src_n;
    end
  end

  // Next state plus next values of the registered pins (pins trail the state by one cycle).
  always_comb begin
    state_n  = state_q;
    load_n   = load_q;
    bit_n    = bit_q;
    phase_n  = phase_q;
    ptr_n    = ptr_q;
    src_n    = src_q;
    gnt_n    = gnt;
    busy_n   = busy;
    shld_n   = (state_q != LOAD);
    serclk_n = (state_q == SHIFT) && phase_q;
    count_n  = (state_q == SHIFT) ? bit_q : 5'd0;
    shift_n  = (state_q == SHIFT);
    unique case (state_q)
      IDLE: begin
        gnt_n  = '0;
        busy_n = 1'b0;
        // A grant still showing from the previous transaction forces one idle cycle.
        if (gnt == '0 && found) begin
          gnt_n   = NREQ'(1) << pick;
          busy_n  = 1'b1;
          src_n   = pick;
          load_n  = 1'b0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (load_q) begin
          bit_n   = 5'd0;
          phase_n = 1'b0;
          state_n = SHIFT;
        end else begin
          load_n = 1'b1;
        end
      end
      SHIFT: begin
        if (!phase_q) begin
          if (bit_q == 5'(BITS - 1)) state_n = DONE;
          else                       phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          bit_n   = bit_q + 5'd1;
        end
      end
      DONE: begin
        ptr_n   = (src_q == SW'(NREQ - 1)) ? '0 : src_q + SW'(1);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt     <= '0;
      busy    <= 1'b0;
      shld    <= 1'b1;
      serclk  <= 1'b0;
      count   <= 5'd0;
      shift_q <= 1'b0;
    end else begin
      gnt     <= gnt_n;
      busy    <= busy_n;
      shld    <= shld_n;
      serclk  <= serclk_n;
      count   <= count_n;
      shift_q <= shift_n;
    end
  end

  // Lanes are sampled while the pins show a shift-phase cycle with serclk low.
  assign capture     = shift_q && !serclk;
  assign last_sample = capture && (count == 5'(BITS - 1));

  always_comb begin
    data_n = data;
    for (int l = 0; l < LANES; l++) begin
      data_n[(LANES-l)*BITS-1 -: BITS] = {lane_sr[l][BITS-2:0], sdin[l]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) lane_sr[l] <= '0;
      data       <= '0;
      data_src   <= '0;
      data_valid <= 1'b0;
    end else begin
      if (capture) begin
        for (int l = 0; l < LANES; l++) lane_sr[l] <= {lane_sr[l][BITS-2:0], sdin[l]};
      end
      if (last_sample) begin
        data     <= data_n;
        data_src <= src_q;
      end
      data_valid <= last_sample;
    end
  end

endmodule

// File: tb/tb_shift_chain_arbiter.sv
// Scoreboard bench for shift_chain_arbiter: behavioural 74LS165 lanes, cyclic round-robin model,
// directed timing checks plus randomized request batches.
module tb_shift_chain_arbiter;
  localparam int unsigned NREQ  = 3;
  localparam int unsigned LANES = 2;
  localparam int unsigned BITS  = 8;
  localparam int unsigned W     = LANES * BITS;
  localparam int unsigned SW    = $clog2(NREQ);

  logic             clk = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic             shld, serclk;
  logic [LANES-1:0] sdin;
  logic [W-1:0]     data;
  logic [SW-1:0]    data_src;
  logic             data_valid, busy;
  logic [4:0]       count;

  shift_chain_arbiter #(.NREQ(NREQ), .LANES(LANES), .BITS(BITS)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .shld(shld), .serclk(serclk),
    .sdin(sdin), .data(data), .data_src(data_src), .data_valid(data_valid),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // Each requester has its own word presented on the parallel inputs while it is granted.
  logic [W-1:0]    words [NREQ];
  logic [W-1:0]    par;
  logic [BITS-1:0] sr [LANES];

  always_comb begin
    par = words[0];
    for (int i = 0; i < NREQ; i++) if (gnt[i]) par = words[i];
  end

  always @(negedge shld or posedge serclk) begin
    for (int l = 0; l < LANES; l++) begin
      if (!shld) sr[l] <= par[(LANES-l)*BITS-1 -: BITS];
      else       sr[l] <= {sr[l][BITS-2:0], 1'b0};
    end
  end

  always_comb for (int l = 0; l < LANES; l++) sdin[l] = sr[l][BITS-1];

  typedef struct { int src; logic [W-1:0] word; } exp_t;
  exp_t q[$];
  int   m_ptr;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every data_valid; checks grant shape every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        if (gnt != '0) chk("gnt_onehot", 64'($onehot(gnt)), 64'd1);
        if (data_valid) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual src=%0d data=%h required none", data_src, data);
          end else begin
            e = q.pop_front();
            chk("data_src", 64'(data_src), 64'(e.src));
            chk("data", 64'(data), 64'(e.word));
            chk("gnt_at_valid", 64'(gnt), 64'(NREQ'(1) << e.src));
          end
        end
      end
    end
  end

  // Lone request with cycle-exact timing; optionally drop req at cycle drop_at.
  task automatic timed_single(input int idx, input logic [W-1:0] w, input int drop_at);
    int pulses, lows, vcycle;
    logic [NREQ-1:0] og;
    words[idx] = w;
    q.push_back('{idx, w});
    m_ptr = (idx + 1) % NREQ;
    og = NREQ'(1) << idx;
    pulses = 0; lows = 0; vcycle = -1;
    @(posedge clk); #1;
    req = og;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1;
      if (c == drop_at) req = '0;
      if (data_valid) begin
        vcycle = c;
        req = '0;
      end
      chk("gnt_window", 64'(gnt), (c <= 2 * BITS + 3) ? 64'(og) : 64'd0);
      if (serclk) pulses++;
      if (!shld) lows++;
      if (c >= 4 && c <= 2 * BITS + 2 && (c % 2 == 0)) chk("count", 64'(count), 64'((c - 4) / 2));
    end
    chk("valid_cycle", 64'(vcycle), 64'(2 * BITS + 3));
    chk("serclk_pulses", 64'(pulses), 64'(BITS - 1));
    chk("load_cycles", 64'(lows), 64'd2);
  endtask

  // Batch of simultaneous requests; the model walks the set cyclically from its pointer.
  task automatic run_batch(input logic [NREQ-1:0] set, input bit hold);
    int n, nserv, served, budget, idx;
    for (int i = 0; i < NREQ; i++) if (set[i]) words[i] = W'($urandom);
    nserv = hold ? 2 * $countones(set) : $countones(set);
    n = 0;
    idx = m_ptr;
    while (n < nserv) begin
      if (set[idx]) begin
        q.push_back('{idx, words[idx]});
        n++;
        m_ptr = (idx + 1) % NREQ;
      end
      idx = (idx + 1) % NREQ;
    end
    @(posedge clk); #1;
    req = set;
    served = 0;
    budget = nserv * 25 + 10;
    while (served < nserv && budget > 0) begin
      @(posedge clk); #1;
      budget--;
      if (data_valid) begin
        served++;
        if (!hold) req[data_src] = 1'b0;
      end
    end
    req = '0;
    if (served < nserv) begin
      checks++;
      errors++;
      $display("FAIL batch_timeout actual=%0d served required=%0d", served, nserv);
      q.delete();
      repeat (30) @(posedge clk);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [W-1:0] pats [4];
    pats[0] = 16'h0000; pats[1] = 16'hFFFF; pats[2] = 16'hAAAA; pats[3] = 16'h8001;
    for (int i = 0; i < NREQ; i++) words[i] = '0;
    m_ptr = 0;
    reset = 1'b1;
    req   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_shld", 64'(shld), 64'd1);
    chk("rst_serclk", 64'(serclk), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_valid", 64'(data_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    timed_single(0, 16'hC003, 0);
    repeat (2) @(posedge clk);
    timed_single(0, 16'h5A3C, 5);
    repeat (2) @(posedge clk);

    run_batch(3'b011, 1'b1);
    run_batch(3'b010, 1'b0);
    run_batch(3'b011, 1'b0);
    run_batch(3'b111, 1'b1);

    // Reset in the middle of SHIFT; after it, service restarts from pointer 0.
    timed_single(0, 16'h0F0F, 0);
    repeat (2) @(posedge clk);
    words[0] = 16'h1111; words[1] = 16'h2222;
    @(posedge clk); #1;
    req = 3'b011;
    repeat (13) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_shld", 64'(shld), 64'd1);
    chk("mid_rst_serclk", 64'(serclk), 64'd0);
    chk("mid_rst_gnt", 64'(gnt), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_data", 64'(data), 64'd0);
    chk("mid_rst_valid", 64'(data_valid), 64'd0);
    reset = 1'b0;
    req = '0;
    q.delete();
    m_ptr = 0;
    repeat (25) @(posedge clk);
    run_batch(3'b110, 1'b0);
    run_batch(3'b011, 1'b0);

    for (int p = 0; p < 4; p++) begin
      timed_single(p % NREQ, pats[p], 0);
      repeat (2) @(posedge clk);
    end

    for (int r = 0; r < 30; r++) begin
      run_batch(NREQ'($urandom_range(1, (1 << NREQ) - 1)), ($urandom % 4) == 0);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
